// File: rtl/bf_radix2_dit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : bf_radix2_dit_pipe
// Purpose  : Three-stage pipelined radix-2 DIT butterfly, Y0 = A + B*W and
//            Y1 = A - B*W, on Q7.8 complex samples with a valid/ready handshake
//            and a sticky saturation flag.
// Options  : define BF_DIT_SCALE_EN for 1/2 scaling of the add/sub outputs.
// Revision : 1.0  initial release
// ============================================================================
module bf_radix2_dit_pipe #(
    parameter int DW   = 16,
    parameter int FRAC = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] A_re,
    input  logic signed [DW-1:0] A_im,
    input  logic signed [DW-1:0] B_re,
    input  logic signed [DW-1:0] B_im,
    input  logic signed [DW-1:0] W_re,
    input  logic signed [DW-1:0] W_im,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] Y0_re,
    output logic signed [DW-1:0] Y0_im,
    output logic signed [DW-1:0] Y1_re,
    output logic signed [DW-1:0] Y1_im,
    output logic                 ovf,
    input  logic                 ovf_clr
);

    localparam logic [DW-1:0]         c_max = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]         c_min = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [2*DW:0]  c_rnd = {{(2*DW){1'b0}}, 1'b1} << (FRAC-1);

    // ------------------------------------------------------------------
    // Arithmetic helpers
    // ------------------------------------------------------------------
    function automatic logic signed [2*DW-1:0] mul(
        input logic signed [DW-1:0] x,
        input logic signed [DW-1:0] y
    );
        logic signed [2*DW-1:0] xe;
        logic signed [2*DW-1:0] ye;
        xe = {{DW{x[DW-1]}}, x};
        ye = {{DW{y[DW-1]}}, y};
        return xe * ye;
    endfunction

    function automatic logic signed [2*DW:0] ext(input logic signed [2*DW-1:0] p);
        return {p[2*DW-1], p};
    endfunction

    // Returns {saturated, value} for a wide rescaled product.
    function automatic logic [DW:0] sat_wide(input logic [2*DW:0] x);
        logic [DW:0] r;
        if (x[2*DW:DW-1] != {(DW+2){x[2*DW]}}) begin
            r = {1'b1, (x[2*DW] ? c_min : c_max)};
        end else begin
            r = {1'b0, x[DW-1:0]};
        end
        return r;
    endfunction

`ifdef BF_DIT_SCALE_EN
    // (s + 1) >>> 1 on the DW+1-bit sum always fits in DW bits.
    function automatic logic [DW-1:0] half(input logic signed [DW:0] s);
        logic signed [DW:0] one;
        one = {{DW{1'b0}}, 1'b1};
        return DW'((s + one) >>> 1);
    endfunction
`else
    // Returns {saturated, value} for a DW+1-bit sum.
    function automatic logic [DW:0] sat_sum(input logic [DW:0] s);
        logic [DW:0] r;
        if (s[DW] != s[DW-1]) begin
            r = {1'b1, (s[DW] ? c_min : c_max)};
        end else begin
            r = {1'b0, s[DW-1:0]};
        end
        return r;
    endfunction
`endif

    // ------------------------------------------------------------------
    // Handshake / stage advance
    // ------------------------------------------------------------------
    logic r_v1;
    logic r_v2;
    logic r_out_valid;
    logic r_ovf;
    logic w_load1;
    logic w_load2;
    logic w_load3;

    assign w_load3  = !r_out_valid || out_ready;
    assign w_load2  = !r_v2 || w_load3;
    assign w_load1  = !r_v1 || w_load2;
    assign in_ready = w_load1;

    // ------------------------------------------------------------------
    // S1: input registers
    // ------------------------------------------------------------------
    logic signed [DW-1:0] r_a1_re;
    logic signed [DW-1:0] r_a1_im;
    logic signed [DW-1:0] r_b1_re;
    logic signed [DW-1:0] r_b1_im;
    logic signed [DW-1:0] r_w1_re;
    logic signed [DW-1:0] r_w1_im;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
        end else if (w_load1) begin
            r_v1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_load1 && in_valid) begin
            r_a1_re <= A_re;
            r_a1_im <= A_im;
            r_b1_re <= B_re;
            r_b1_im <= B_im;
            r_w1_re <= W_re;
            r_w1_im <= W_im;
        end
    end

    // ------------------------------------------------------------------
    // S2: A delay and the four partial products
    // ------------------------------------------------------------------
    logic signed [DW-1:0]   r_a2_re;
    logic signed [DW-1:0]   r_a2_im;
    logic signed [2*DW-1:0] r_brwr;
    logic signed [2*DW-1:0] r_biwi;
    logic signed [2*DW-1:0] r_brwi;
    logic signed [2*DW-1:0] r_biwr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2 <= 1'b0;
        end else if (w_load2) begin
            r_v2 <= r_v1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_load2 && r_v1) begin
            r_a2_re <= r_a1_re;
            r_a2_im <= r_a1_im;
            r_brwr  <= mul(r_b1_re, r_w1_re);
            r_biwi  <= mul(r_b1_im, r_w1_im);
            r_brwi  <= mul(r_b1_re, r_w1_im);
            r_biwr  <= mul(r_b1_im, r_w1_re);
        end
    end

    // ------------------------------------------------------------------
    // S3 combinational: product combine, round half-up, saturate, add/sub
    // ------------------------------------------------------------------
    logic signed [2*DW:0] w_pre;
    logic signed [2*DW:0] w_pim;
    logic signed [2*DW:0] w_pre_sh;
    logic signed [2*DW:0] w_pim_sh;
    logic                 w_t_re_sat;
    logic                 w_t_im_sat;
    logic signed [DW-1:0] w_t_re;
    logic signed [DW-1:0] w_t_im;
    logic signed [DW:0]   w_s0_re;
    logic signed [DW:0]   w_s0_im;
    logic signed [DW:0]   w_s1_re;
    logic signed [DW:0]   w_s1_im;
    logic signed [DW-1:0] w_y0_re;
    logic signed [DW-1:0] w_y0_im;
    logic signed [DW-1:0] w_y1_re;
    logic signed [DW-1:0] w_y1_im;
    logic                 w_sum_sat;
    logic                 w_sat_any;

    assign w_pre    = ext(r_brwr) - ext(r_biwi);
    assign w_pim    = ext(r_brwi) + ext(r_biwr);
    assign w_pre_sh = (w_pre + c_rnd) >>> FRAC;
    assign w_pim_sh = (w_pim + c_rnd) >>> FRAC;

    assign {w_t_re_sat, w_t_re} = sat_wide(w_pre_sh);
    assign {w_t_im_sat, w_t_im} = sat_wide(w_pim_sh);

    assign w_s0_re = {r_a2_re[DW-1], r_a2_re} + {w_t_re[DW-1], w_t_re};
    assign w_s0_im = {r_a2_im[DW-1], r_a2_im} + {w_t_im[DW-1], w_t_im};
    assign w_s1_re = {r_a2_re[DW-1], r_a2_re} - {w_t_re[DW-1], w_t_re};
    assign w_s1_im = {r_a2_im[DW-1], r_a2_im} - {w_t_im[DW-1], w_t_im};

`ifdef BF_DIT_SCALE_EN
    assign w_y0_re   = half(w_s0_re);
    assign w_y0_im   = half(w_s0_im);
    assign w_y1_re   = half(w_s1_re);
    assign w_y1_im   = half(w_s1_im);
    assign w_sum_sat = 1'b0;
`else
    logic w_y0_re_sat;
    logic w_y0_im_sat;
    logic w_y1_re_sat;
    logic w_y1_im_sat;

    assign {w_y0_re_sat, w_y0_re} = sat_sum(w_s0_re);
    assign {w_y0_im_sat, w_y0_im} = sat_sum(w_s0_im);
    assign {w_y1_re_sat, w_y1_re} = sat_sum(w_s1_re);
    assign {w_y1_im_sat, w_y1_im} = sat_sum(w_s1_im);
    assign w_sum_sat = w_y0_re_sat | w_y0_im_sat | w_y1_re_sat | w_y1_im_sat;
`endif

    assign w_sat_any = w_t_re_sat | w_t_im_sat | w_sum_sat;

    // ------------------------------------------------------------------
    // S3: output register; holds while the consumer stalls
    // ------------------------------------------------------------------
    logic signed [DW-1:0] r_y0_re;
    logic signed [DW-1:0] r_y0_im;
    logic signed [DW-1:0] r_y1_re;
    logic signed [DW-1:0] r_y1_im;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_y0_re     <= '0;
            r_y0_im     <= '0;
            r_y1_re     <= '0;
            r_y1_im     <= '0;
        end else if (w_load3) begin
            r_out_valid <= r_v2;
            if (r_v2) begin
                r_y0_re <= w_y0_re;
                r_y0_im <= w_y0_im;
                r_y1_re <= w_y1_re;
                r_y1_im <= w_y1_im;
            end
        end
    end

    // Sticky flag: a new saturation event beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_load3 && r_v2 && w_sat_any) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign Y0_re     = r_y0_re;
    assign Y0_im     = r_y0_im;
    assign Y1_re     = r_y1_re;
    assign Y1_im     = r_y1_im;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_bf_radix2_dit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_bf_radix2_dit_pipe
// Purpose  : Self-checking bench for bf_radix2_dit_pipe (directed table,
//            backpressure, mid-stream reset and randomized traffic).
// Revision : 1.0  initial release
// ============================================================================
module tb_bf_radix2_dit_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        ovf;
    logic        ovf_clr = 1'b0;
    logic [15:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0, w_re = '0, w_im = '0;
    logic [15:0] y0_re, y0_im, y1_re, y1_im;

    always #5 clk = ~clk;

    bf_radix2_dit_pipe #(.DW(16), .FRAC(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .A_re(a_re), .A_im(a_im), .B_re(b_re), .B_im(b_im), .W_re(w_re), .W_im(w_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .Y0_re(y0_re), .Y0_im(y0_im), .Y1_re(y1_re), .Y1_im(y1_im),
        .ovf(ovf), .ovf_clr(ovf_clr)
    );

    int total = 0;
    int bad = 0;
    int out_cnt = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;

    // Reference model: plain integer arithmetic on the butterfly equations.
    function automatic int sat16(longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic int sx(logic [15:0] x);
        return int'($signed(x));
    endfunction

    function automatic logic [63:0] model(int ar, int ai, int br, int bi, int wr, int wi);
        longint pre, pim;
        int tr, ti, y0r, y0i, y1r, y1i;
        pre = longint'(br) * longint'(wr) - longint'(bi) * longint'(wi);
        pim = longint'(br) * longint'(wi) + longint'(bi) * longint'(wr);
        tr  = sat16((pre + 128) >>> 8);
        ti  = sat16((pim + 128) >>> 8);
`ifdef BF_DIT_SCALE_EN
        y0r = (ar + tr + 1) >>> 1;
        y0i = (ai + ti + 1) >>> 1;
        y1r = (ar - tr + 1) >>> 1;
        y1i = (ai - ti + 1) >>> 1;
`else
        y0r = sat16(longint'(ar + tr));
        y0i = sat16(longint'(ai + ti));
        y1r = sat16(longint'(ar - tr));
        y1i = sat16(longint'(ai - ti));
`endif
        return {16'(y0r), 16'(y0i), 16'(y1r), 16'(y1i)};
    endfunction

    // Scoreboard: transfers are decided by the values stable at the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected got=%h required=none", {y0_re, y0_im, y1_re, y1_im});
                end else begin
                    mon_exp = exp_q.pop_front();
                    out_cnt++;
                    if ({y0_re, y0_im, y1_re, y1_im} !== mon_exp) begin
                        bad++;
                        $display("FAIL sb_data got=%h required=%h", {y0_re, y0_im, y1_re, y1_im}, mon_exp);
                    end
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(sx(a_re), sx(a_im), sx(b_re), sx(b_im), sx(w_re), sx(w_im)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    task automatic drive(input logic [15:0] ar, ai, br, bi, wr, wi);
        a_re = ar; a_im = ai; b_re = br; b_im = bi; w_re = wr; w_im = wi;
    endtask

    typedef struct {
        logic [15:0] ar, ai, br, bi, wr, wi;
        logic [15:0] y0r, y0i, y1r, y1i;
        logic        ovf;
    } vec_t;

    vec_t        tab[8];
    logic [15:0] bp[5][6];

    task automatic drive_vec(input int i);
        drive(tab[i].ar, tab[i].ai, tab[i].br, tab[i].bi, tab[i].wr, tab[i].wi);
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        step();
        while (!out_valid && lat < 10) begin
            step();
            lat++;
        end
    endtask

    initial begin
        int lat, acc, cnt0, n, seen;
        logic [63:0] held;

`ifdef BF_DIT_SCALE_EN
        tab[0] = '{16'h0100, 16'h0000, 16'h0200, 16'h0000, 16'h0100, 16'h0000, 16'h0180, 16'h0000, 16'hFF80, 16'h0000, 1'b0};
        tab[1] = '{16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0080, 16'h0000, 16'hFF80, 1'b0};
        tab[2] = '{16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0080, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        tab[3] = '{16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0080, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        tab[4] = '{16'h7F00, 16'h0000, 16'h7F00, 16'h0000, 16'h0100, 16'h0000, 16'h7F00, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        tab[5] = '{16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 16'h4000, 16'h0000, 16'hC001, 16'h0000, 1'b1};
        tab[6] = '{16'h8000, 16'h0000, 16'h0100, 16'h0000, 16'h0100, 16'h0000, 16'hC080, 16'h0000, 16'hBF80, 16'h0000, 1'b0};
        tab[7] = '{16'h0080, 16'hFF80, 16'h0100, 16'h0200, 16'h00B5, 16'hFF4B, 16'h0150, 16'h001B, 16'hFF31, 16'hFF66, 1'b0};
`else
        tab[0] = '{16'h0100, 16'h0000, 16'h0200, 16'h0000, 16'h0100, 16'h0000, 16'h0300, 16'h0000, 16'hFF00, 16'h0000, 1'b0};
        tab[1] = '{16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0100, 16'h0000, 16'hFF00, 1'b0};
        tab[2] = '{16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0080, 16'h0000, 16'h0001, 16'h0000, 16'hFFFF, 16'h0000, 1'b0};
        tab[3] = '{16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0080, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        tab[4] = '{16'h7F00, 16'h0000, 16'h7F00, 16'h0000, 16'h0100, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 1'b1};
        tab[5] = '{16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 16'h8001, 16'h0000, 1'b1};
        tab[6] = '{16'h8000, 16'h0000, 16'h0100, 16'h0000, 16'h0100, 16'h0000, 16'h8100, 16'h0000, 16'h8000, 16'h0000, 1'b1};
        tab[7] = '{16'h0080, 16'hFF80, 16'h0100, 16'h0200, 16'h00B5, 16'hFF4B, 16'h029F, 16'h0035, 16'hFE61, 16'hFECB, 1'b0};
`endif

        // Reset state
        rst = 1'b1;
        step();
        step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_y", {y0_re, y0_im, y1_re, y1_im}, 64'd0);
        rst = 1'b0;
        step();

        // Directed table, one sample at a time
        for (int i = 0; i < 8; i++) begin
            ovf_clr = 1'b1;
            step();
            ovf_clr = 1'b0;
            drive_vec(i);
            in_valid = 1'b1;
            wait_out(lat);
            in_valid = 1'b0;
            // in_valid was dropped one cycle late; re-sync by checking after the fact
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd3);
            chk($sformatf("vec%0d_y", i), {y0_re, y0_im, y1_re, y1_im},
                {tab[i].y0r, tab[i].y0i, tab[i].y1r, tab[i].y1i});
            chk($sformatf("vec%0d_ovf", i), 64'(ovf), 64'(tab[i].ovf));
            n = 0;
            while ((out_valid || exp_q.size() != 0) && n < 20) begin
                step();
                n++;
            end
        end

        // Sticky ovf and its clear
        drive_vec(5);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("ovf_set", 64'(ovf), 64'd1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clear", 64'(ovf), 64'd0);
        step();

        // Backpressure: 5 samples offered with the consumer stalled
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 6; j++)
                bp[i][j] = 16'($urandom);
        cnt0 = out_cnt;
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            drive(bp[acc][0], bp[acc][1], bp[acc][2], bp[acc][3], bp[acc][4], bp[acc][5]);
            in_valid = 1'b1;
            #1;
            if (in_ready) acc++;
            step();
        end
        chk("bp_accepted", 64'(acc), 64'd3);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        held = {y0_re, y0_im, y1_re, y1_im};
        step();
        step();
        step();
        chk("bp_hold_data", {y0_re, y0_im, y1_re, y1_im}, held);
        chk("bp_hold_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        n = 0;
        while (acc < 5 && n < 20) begin
            drive(bp[acc][0], bp[acc][1], bp[acc][2], bp[acc][3], bp[acc][4], bp[acc][5]);
            in_valid = 1'b1;
            #1;
            if (in_ready) acc++;
            step();
            n++;
        end
        in_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        step();
        chk("bp_drained", 64'(out_cnt - cnt0), 64'd5);

        // Reset with three samples in flight
        drive_vec(5);
        in_valid = 1'b1;
        step();
        drive_vec(0);
        step();
        drive_vec(7);
        step();
        in_valid = 1'b0;
        chk("mid_out_valid_before", 64'(out_valid), 64'd1);
        chk("mid_ovf_before", 64'(ovf), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_ovf", 64'(ovf), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) seen++;
            step();
        end
        chk("mid_rst_no_stale", 64'(seen), 64'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            drive(16'($urandom), 16'($urandom), 16'($urandom),
                  16'($urandom), 16'($urandom), 16'($urandom));
            out_ready = ($urandom_range(0, 9) < 7);
            ovf_clr = ($urandom_range(0, 15) == 0);
            step();
        end
        in_valid = 1'b0;
        ovf_clr = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        chk("rand_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
